apb_fifo_completer: RTL and testbench

- APB completer (responder) that bridges the APB bus to two streaming FIFOs: a TX FIFO filled by APB writes and drained by a valid/ready stream, and an RX FIFO filled by a valid/ready stream and drained by APB reads.
- Sits behind apb_master on the same apb_clk domain.
- Stalls the bus with wait states while a FIFO is blocked, and terminates with apb_slverr on timeout or on an illegal access.

---
 rtl/apb_fifo_completer.sv | 228 ++++++++++++++++++++++
 tb/tb_apb_fifo_completer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_completer.sv
// APB completer bridging the bus to a TX stream FIFO (filled by writes) and an
// RX stream FIFO (drained by reads), with wait-state stalling and timeout.
module apb_fifo_completer #(
  parameter int         DEPTH          = 8,
  parameter logic [7:0] WAIT_LIMIT_RST = 8'd16
) (
  input  logic        apb_clk,
  input  logic        sys_reset,
  input  logic [7:0]  apb_addr,
  input  logic        apb_selx,
  input  logic        apb_en,
  input  logic        apb_write,
  input  logic [31:0] apb_wdata,
  output logic [31:0] apb_rdata,
  output logic        apb_ready,
  output logic        apb_slverr,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CTRL   = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t         state_r;
  logic [7:0]     stall_cnt_r;
  logic [7:0]     wait_limit_r;
  logic           err_sticky_r;

  logic [31:0]    tx_mem_r [DEPTH];
  logic [AW-1:0]  tx_wptr_r, tx_rptr_r;
  logic [CW-1:0]  tx_cnt_r;
  logic [31:0]    rx_mem_r [DEPTH];
  logic [AW-1:0]  rx_wptr_r, rx_rptr_r;
  logic [CW-1:0]  rx_cnt_r;

  logic           tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic           tx_push_s, tx_pop_s, tx_flush_s;
  logic           rx_push_s, rx_pop_s, rx_flush_s;
  logic           is_txw_s, is_rxr_s, is_ctrlw_s, legal_s, blocked_s, do_op_s;
  logic           ctrl_wr_s;
  logic [31:0]    status_s, rd_val_s;

  assign tx_empty_s = (tx_cnt_r == {CW{1'b0}});
  assign tx_full_s  = (tx_cnt_r == FULL_CNT);
  assign rx_empty_s = (rx_cnt_r == {CW{1'b0}});
  assign rx_full_s  = (rx_cnt_r == FULL_CNT);

  assign tx_valid = ~tx_empty_s;
  assign tx_data  = tx_mem_r[tx_rptr_r];
  assign rx_ready = sys_reset & ~rx_full_s;

  assign tx_pop_s   = ~tx_empty_s & tx_ready;
  assign rx_push_s  = rx_valid & ~rx_full_s;
  assign tx_push_s  = do_op_s & is_txw_s;
  assign rx_pop_s   = do_op_s & is_rxr_s;
  assign ctrl_wr_s  = do_op_s & is_ctrlw_s;
  assign tx_flush_s = ctrl_wr_s & apb_wdata[0];
  assign rx_flush_s = ctrl_wr_s & apb_wdata[1];

  assign status_s = {7'd0, err_sticky_r, 8'(rx_cnt_r), 8'(tx_cnt_r),
                     4'd0, rx_full_s, rx_empty_s, tx_full_s, tx_empty_s};

  // Access decode; a blocked FIFO access only proceeds once the count frees up.
  always_comb begin
    is_txw_s   = (apb_addr == ADDR_TXDATA) && apb_write;
    is_rxr_s   = (apb_addr == ADDR_RXDATA) && !apb_write;
    is_ctrlw_s = (apb_addr == ADDR_CTRL) && apb_write;
    legal_s    = is_txw_s || is_rxr_s || (apb_addr == ADDR_CTRL) ||
                 ((apb_addr == ADDR_STATUS) && !apb_write);
    blocked_s  = (is_txw_s && tx_full_s) || (is_rxr_s && rx_empty_s);
    case (state_r)
      ST_IDLE:  do_op_s = apb_selx && apb_en && legal_s && !blocked_s;
      ST_STALL: do_op_s = apb_selx && !blocked_s;
      default:  do_op_s = 1'b0;
    endcase
  end

  // Read-data mux for legal reads.
  always_comb begin
    rd_val_s = 32'd0;
    case (apb_addr)
      ADDR_RXDATA: rd_val_s = rx_mem_r[rx_rptr_r];
      ADDR_STATUS: rd_val_s = status_s;
      ADDR_CTRL:   rd_val_s = {16'd0, wait_limit_r, 8'd0};
      default:     rd_val_s = 32'd0;
    endcase
  end

  // FIFO storage arrays carry no reset.
  always_ff @(posedge apb_clk) begin
    if (tx_push_s) tx_mem_r[tx_wptr_r] <= apb_wdata;
    if (rx_push_s) rx_mem_r[rx_wptr_r] <= rx_data;
  end

  // TX pointers and count; flush wins over a coincident stream pop.
  always_ff @(posedge apb_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      tx_wptr_r <= {AW{1'b0}};
      tx_rptr_r <= {AW{1'b0}};
      tx_cnt_r  <= {CW{1'b0}};
    end else if (tx_flush_s) begin
      tx_wptr_r <= {AW{1'b0}};
      tx_rptr_r <= {AW{1'b0}};
      tx_cnt_r  <= {CW{1'b0}};
    end else begin
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + AW'(1);
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + AW'(1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + CW'(1);
        2'b01:   tx_cnt_r <= tx_cnt_r - CW'(1);
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // RX pointers and count; flush wins over a coincident stream push.
  always_ff @(posedge apb_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      rx_wptr_r <= {AW{1'b0}};
      rx_rptr_r <= {AW{1'b0}};
      rx_cnt_r  <= {CW{1'b0}};
    end else if (rx_flush_s) begin
      rx_wptr_r <= {AW{1'b0}};
      rx_rptr_r <= {AW{1'b0}};
      rx_cnt_r  <= {CW{1'b0}};
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + AW'(1);
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + AW'(1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + CW'(1);
        2'b01:   rx_cnt_r <= rx_cnt_r - CW'(1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  // Transfer FSM with registered response, control register and sticky error.
  always_ff @(posedge apb_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_r      <= ST_IDLE;
      stall_cnt_r  <= 8'd0;
      wait_limit_r <= WAIT_LIMIT_RST;
      err_sticky_r <= 1'b0;
      apb_ready    <= 1'b0;
      apb_slverr   <= 1'b0;
      apb_rdata    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          apb_ready  <= 1'b0;
          apb_slverr <= 1'b0;
          apb_rdata  <= 32'd0;
          if (apb_selx && apb_en) begin
            if (!legal_s) begin
              apb_ready    <= 1'b1;
              apb_slverr   <= 1'b1;
              err_sticky_r <= 1'b1;
              state_r      <= ST_RESP;
            end else if (!blocked_s) begin
              apb_ready <= 1'b1;
              apb_rdata <= apb_write ? 32'd0 : rd_val_s;
              if (is_ctrlw_s) begin
                wait_limit_r <= apb_wdata[15:8];
                if (apb_wdata[2]) err_sticky_r <= 1'b0;
              end
              state_r <= ST_RESP;
            end else if (wait_limit_r == 8'd0) begin
              apb_ready    <= 1'b1;
              apb_slverr   <= 1'b1;
              err_sticky_r <= 1'b1;
              state_r      <= ST_RESP;
            end else begin
              stall_cnt_r <= 8'd0;
              state_r     <= ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (!apb_selx) begin
            state_r <= ST_IDLE;
          end else if (!blocked_s) begin
            apb_ready  <= 1'b1;
            apb_slverr <= 1'b0;
            apb_rdata  <= apb_write ? 32'd0 : rd_val_s;
            state_r    <= ST_RESP;
          end else if ((stall_cnt_r + 8'd1) == wait_limit_r) begin
            apb_ready    <= 1'b1;
            apb_slverr   <= 1'b1;
            apb_rdata    <= 32'd0;
            err_sticky_r <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
          end
        end
        ST_RESP: begin
          apb_ready  <= 1'b0;
          apb_slverr <= 1'b0;
          apb_rdata  <= 32'd0;
          state_r    <= ST_IDLE;
        end
        default: begin
          apb_ready  <= 1'b0;
          apb_slverr <= 1'b0;
          apb_rdata  <= 32'd0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fifo_completer.sv
// Directed self-checking bench for apb_fifo_completer (DEPTH=8, reset wait_limit=16).
module tb_apb_fifo_completer;

  logic        apb_clk;
  logic        sys_reset;
  logic [7:0]  apb_addr;
  logic        apb_selx;
  logic        apb_en;
  logic        apb_write;
  logic [31:0] apb_wdata;
  logic [31:0] apb_rdata;
  logic        apb_ready;
  logic        apb_slverr;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int   total = 0;
  int   bad   = 0;
  logic ready_with_access = 1'b0;

  apb_fifo_completer #(.DEPTH(8), .WAIT_LIMIT_RST(8'd16)) dut (
    .apb_clk   (apb_clk),
    .sys_reset (sys_reset),
    .apb_addr  (apb_addr),
    .apb_selx  (apb_selx),
    .apb_en    (apb_en),
    .apb_write (apb_write),
    .apb_wdata (apb_wdata),
    .apb_rdata (apb_rdata),
    .apb_ready (apb_ready),
    .apb_slverr(apb_slverr),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  initial apb_clk = 1'b0;
  always #5 apb_clk = ~apb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer: setup, access, wait for ready (bounded), then idle.
  task automatic apb_xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic err,
                          output int waits, output logic ready_after);
    int n;
    @(negedge apb_clk);
    apb_addr = a; apb_write = w; apb_wdata = d; apb_selx = 1'b1; apb_en = 1'b0;
    @(negedge apb_clk);
    apb_en = 1'b1;
    if (ready_with_access) tx_ready = 1'b1;
    n = 0;
    @(posedge apb_clk); #1;
    while (!apb_ready && n < 64) begin
      @(posedge apb_clk); #1;
      n++;
    end
    chk("ready_timeout", {31'd0, apb_ready}, 32'd1);
    rd = apb_rdata; err = apb_slverr; waits = n;
    @(negedge apb_clk);
    apb_selx = 1'b0; apb_en = 1'b0;
    @(posedge apb_clk); #1;
    ready_after = apb_ready;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err, ra;
    int          wt;

    sys_reset = 1'b0; apb_addr = 8'h00; apb_selx = 1'b0; apb_en = 1'b0;
    apb_write = 1'b0; apb_wdata = 32'd0; tx_ready = 1'b0; rx_data = 32'd0; rx_valid = 1'b0;
    repeat (3) @(negedge apb_clk);
    chk("rst_ready", {31'd0, apb_ready}, 32'd0);
    chk("rst_slverr", {31'd0, apb_slverr}, 32'd0);
    chk("rst_rdata", apb_rdata, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    sys_reset = 1'b1;
    @(negedge apb_clk);
    chk("rx_ready_out", {31'd0, rx_ready}, 32'd1);
    apb_xfer(8'h0C, 1'b0, 32'd0, rd, err, wt, ra);
    chk("ctrl_rst_val", rd, 32'h0000_1000);

    // Single TX write
    apb_xfer(8'h00, 1'b1, 32'hA5, rd, err, wt, ra);
    chk("t1_waits", 32'(wt), 32'd0);
    chk("t1_slverr", {31'd0, err}, 32'd0);
    chk("t1_pulse1", {31'd0, ra}, 32'd0);
    chk("t1_tx_valid", {31'd0, tx_valid}, 32'd1);
    chk("t1_tx_data", tx_data, 32'hA5);
    apb_xfer(8'h08, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t1_status", rd, 32'h0000_0104);

    // Fill TX, then timeout a 9th write with wait_limit=4
    apb_xfer(8'h0C, 1'b1, 32'h0000_0401, rd, err, wt, ra);
    for (int i = 1; i <= 8; i++) begin
      apb_xfer(8'h00, 1'b1, 32'(i), rd, err, wt, ra);
      chk("t2_fill_waits", 32'(wt), 32'd0);
    end
    apb_xfer(8'h08, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t2_status_full", rd, 32'h0000_0806);
    apb_xfer(8'h00, 1'b1, 32'd9, rd, err, wt, ra);
    chk("t2_timeout_waits", 32'(wt), 32'd4);
    chk("t2_timeout_slverr", {31'd0, err}, 32'd1);
    apb_xfer(8'h08, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t2_status_err", rd, 32'h0100_0806);
    chk("t2_head", tx_data, 32'd1);

    // Stalled 9th write freed by one stream pop
    fork
      apb_xfer(8'h00, 1'b1, 32'd9, rd, err, wt, ra);
      begin
        do @(posedge apb_clk); while (!(apb_selx && apb_en));
        @(negedge apb_clk); tx_ready = 1'b1;
        @(negedge apb_clk); tx_ready = 1'b0;
      end
    join
    chk("t3_waits", 32'(wt), 32'd2);
    chk("t3_slverr", {31'd0, err}, 32'd0);
    @(negedge apb_clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", tx_data, 32'(i + 2));
      @(negedge apb_clk);
    end
    tx_ready = 1'b0;
    chk("t3_drained", {31'd0, tx_valid}, 32'd0);

    // RX stream in, APB reads out
    rx_valid = 1'b1; rx_data = 32'h11;
    @(negedge apb_clk); rx_data = 32'h22;
    @(negedge apb_clk); rx_valid = 1'b0;
    apb_xfer(8'h04, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t4_rd0", rd, 32'h11);
    chk("t4_rd0_err", {31'd0, err}, 32'd0);
    apb_xfer(8'h04, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t4_rd1", rd, 32'h22);
    apb_xfer(8'h0C, 1'b1, 32'h0000_0000, rd, err, wt, ra);
    apb_xfer(8'h04, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t4_empty_err", {31'd0, err}, 32'd1);
    chk("t4_empty_rdata", rd, 32'd0);
    chk("t4_empty_waits", 32'(wt), 32'd0);

    // Illegal accesses, then err_clr
    apb_xfer(8'h10, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t5_rd10_err", {31'd0, err}, 32'd1);
    chk("t5_rd10_waits", 32'(wt), 32'd0);
    apb_xfer(8'h08, 1'b1, 32'hFFFF_FFFF, rd, err, wt, ra);
    chk("t5_wr08_err", {31'd0, err}, 32'd1);
    chk("t5_wr08_waits", 32'(wt), 32'd0);
    apb_xfer(8'h00, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t5_rd00_err", {31'd0, err}, 32'd1);
    chk("t5_rd00_rdata", rd, 32'd0);
    apb_xfer(8'h0C, 1'b1, 32'h0000_0004, rd, err, wt, ra);
    apb_xfer(8'h08, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t5_status_clr", rd, 32'h0000_0005);

    // TX flush against a coincident stream pop
    for (int i = 0; i < 3; i++) apb_xfer(8'h00, 1'b1, 32'hC0 + 32'(i), rd, err, wt, ra);
    apb_xfer(8'h08, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t6_status3", rd, 32'h0000_0304);
    ready_with_access = 1'b1;
    apb_xfer(8'h0C, 1'b1, 32'h0000_0001, rd, err, wt, ra);
    ready_with_access = 1'b0;
    chk("t6_flush_valid", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    apb_xfer(8'h08, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t6_flush_status", rd, 32'h0000_0005);

    // Reset in the middle of a stalled read
    apb_xfer(8'h0C, 1'b1, 32'h0000_2000, rd, err, wt, ra);
    apb_xfer(8'h00, 1'b1, 32'hB1, rd, err, wt, ra);
    apb_xfer(8'h00, 1'b1, 32'hB2, rd, err, wt, ra);
    @(negedge apb_clk);
    apb_addr = 8'h04; apb_write = 1'b0; apb_selx = 1'b1; apb_en = 1'b0;
    @(negedge apb_clk);
    apb_en = 1'b1;
    @(posedge apb_clk); #1;
    chk("t7_stall0", {31'd0, apb_ready}, 32'd0);
    @(posedge apb_clk); #1;
    chk("t7_stall1", {31'd0, apb_ready}, 32'd0);
    @(negedge apb_clk);
    sys_reset = 1'b0;
    #1;
    chk("t7_rst_ready", {31'd0, apb_ready}, 32'd0);
    chk("t7_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    @(negedge apb_clk);
    apb_selx = 1'b0; apb_en = 1'b0;
    @(negedge apb_clk);
    sys_reset = 1'b1;
    @(negedge apb_clk);
    chk("t7_post_ready", {31'd0, apb_ready}, 32'd0);
    chk("t7_post_tx_valid", {31'd0, tx_valid}, 32'd0);
    apb_xfer(8'h08, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t7_status", rd, 32'h0000_0005);
    apb_xfer(8'h0C, 1'b0, 32'd0, rd, err, wt, ra);
    chk("t7_ctrl", rd, 32'h0000_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
